board_ctrl: RTL

- Sequential move controller that sits directly upstream of detect_win.
- Owns the 3x3 board register: accepts player moves, rejects illegal ones, and alternates turns.
- Drives pos1..pos9 straight into detect_win, then samples its winner/who_win to end the game on a win or a draw.
- Holds the final board until a new game is requested.

---
 rtl/board_ctrl.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/board_ctrl.sv
// board_ctrl: tic-tac-toe move controller. It owns the 3x3 board, accepts or
// rejects player moves, alternates turns and ends the game on a win or a draw.
// The board is driven into detect_win, and its winner/who_win answer is sampled
// in the single CHECK cycle that follows every accepted move.
//
// Handshake: a move is offered by holding move_valid high for one cycle with
// move_pos set. It is considered only while move_ready=1 (PLAY state). In that
// cycle it is either placed (the state moves to CHECK) or rejected (illegal_move
// pulses on the next cycle). While move_ready=0 (CHECK/OVER) move_valid is
// ignored and is never flagged as illegal.
module board_ctrl #(
  parameter logic [1:0] FIRST_PLAYER = 2'b01
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       new_game,
  input  logic       move_valid,
  input  logic [3:0] move_pos,
  input  logic       winner,
  input  logic [1:0] who_win,
  output logic [1:0] pos1,
  output logic [1:0] pos2,
  output logic [1:0] pos3,
  output logic [1:0] pos4,
  output logic [1:0] pos5,
  output logic [1:0] pos6,
  output logic [1:0] pos7,
  output logic [1:0] pos8,
  output logic [1:0] pos9,
  output logic [1:0] turn,
  output logic       move_ready,
  output logic       illegal_move,
  output logic [3:0] move_count,
  output logic       game_over,
  output logic       draw,
  output logic [1:0] result,
  output logic [1:0] state_dbg
);

  localparam logic [1:0] S_PLAY  = 2'd0;
  localparam logic [1:0] S_CHECK = 2'd1;
  localparam logic [1:0] S_OVER  = 2'd2;

  logic [1:0] r_state;
  logic [1:0] w_state_next;

  logic [1:0] r_board [9];
  logic [1:0] r_turn;
  logic [3:0] r_count;
  logic       r_illegal;
  logic       r_move_ready;
  logic       r_game_over;
  logic       r_draw;
  logic [1:0] r_result;

  logic       w_pos_ok;
  logic [3:0] w_idx;
  logic [1:0] w_cell;
  logic       w_legal;
  logic       w_reject;
  logic       w_clear;

  logic [1:0] w_turn_next;
  logic [1:0] w_result_next;
  logic       w_draw_next;

  // Reset outranks new_game; both wipe the whole game.
  assign w_clear  = reset | new_game;

  // Decode the requested cell; out-of-range positions never index the board.
  assign w_pos_ok = (move_pos >= 4'd1) && (move_pos <= 4'd9);
  assign w_idx    = move_pos - 4'd1;
  assign w_cell   = w_pos_ok ? r_board[w_idx] : 2'b00;
  assign w_legal  = (r_state == S_PLAY) && move_valid && w_pos_ok && (w_cell == 2'b00);
  assign w_reject = (r_state == S_PLAY) && move_valid && !w_legal;

  // State register.
  always_ff @(posedge clk) begin
    if (w_clear) begin
      r_state <= S_PLAY;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic: PLAY waits for a legal move, CHECK lasts one cycle,
  // OVER is left only through reset/new_game.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_PLAY:  if (w_legal) w_state_next = S_CHECK;
      S_CHECK: begin
        if (winner || (r_count == 4'd9)) w_state_next = S_OVER;
        else                             w_state_next = S_PLAY;
      end
      S_OVER:  w_state_next = S_OVER;
      default: w_state_next = S_PLAY;
    endcase
  end

  // Outcome logic: resolve the move just placed. Winner is tested before the
  // full-board condition so a win on the ninth move is not called a draw.
  always_comb begin
    w_turn_next   = r_turn;
    w_result_next = r_result;
    w_draw_next   = r_draw;
    if (r_state == S_CHECK) begin
      if (winner) begin
        w_result_next = who_win;
      end else if (r_count == 4'd9) begin
        w_draw_next   = 1'b1;
        w_result_next = 2'b00;
      end else begin
        w_turn_next   = (r_turn == 2'b01) ? 2'b10 : 2'b01;
      end
    end
  end

  // Board, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (w_clear) begin
      for (int i = 0; i < 9; i++) r_board[i] <= 2'b00;
      r_turn       <= FIRST_PLAYER;
      r_count      <= 4'd0;
      r_illegal    <= 1'b0;
      r_move_ready <= 1'b1;
      r_game_over  <= 1'b0;
      r_draw       <= 1'b0;
      r_result     <= 2'b00;
    end else begin
      if (w_legal) begin
        r_board[w_idx] <= r_turn;
        r_count        <= r_count + 4'd1;
      end
      r_turn       <= w_turn_next;
      r_result     <= w_result_next;
      r_draw       <= w_draw_next;
      r_illegal    <= w_reject;
      r_move_ready <= (w_state_next == S_PLAY);
      r_game_over  <= (w_state_next == S_OVER);
    end
  end

  assign pos1         = r_board[0];
  assign pos2         = r_board[1];
  assign pos3         = r_board[2];
  assign pos4         = r_board[3];
  assign pos5         = r_board[4];
  assign pos6         = r_board[5];
  assign pos7         = r_board[6];
  assign pos8         = r_board[7];
  assign pos9         = r_board[8];
  assign turn         = r_turn;
  assign move_ready   = r_move_ready;
  assign illegal_move = r_illegal;
  assign move_count   = r_count;
  assign game_over    = r_game_over;
  assign draw         = r_draw;
  assign result       = r_result;
  assign state_dbg    = r_state;

endmodule
